// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and helpers for the single-cycle RV32I core.
//   - 7-bit major opcodes
//   - funct3 codes for OP/OP-IMM and for conditional branches
//   - ALU operation enum plus the ALU datapath and its decode function
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   // Major opcodes (instruction bits [6:0])
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // funct3 for OP / OP-IMM
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   // funct3 for BRANCH
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND
   } alu_op_e;

   // Instruction bit 30 selects SUB/SRA. SUB only exists in the register
   // form: ADDI with imm[10] set is still an add, while SRAI does use it.
   function automatic alu_op_e alu_op_decode(input logic [2:0] funct3,
                                             input logic       alt,
                                             input logic       is_reg);
      alu_op_e op;
      case (funct3)
         F3_ADD_SUB: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

   // 32-bit wrap-around ALU; shift amount is the low 5 bits of b.
   function automatic logic [31:0] alu_compute(input alu_op_e     op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
      logic [31:0] res;
      case (op)
         ALU_ADD:  res = a + b;
         ALU_SUB:  res = a - b;
         ALU_SLL:  res = a << b[4:0];
         ALU_SLT:  res = {31'b0, ($signed(a) < $signed(b))};
         ALU_SLTU: res = {31'b0, (a < b)};
         ALU_XOR:  res = a ^ b;
         ALU_SRL:  res = a >> b[4:0];
         ALU_SRA:  res = $signed(a) >>> b[4:0];
         ALU_OR:   res = a | b;
         ALU_AND:  res = a & b;
         default:  res = a + b;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem
// Word-addressed instruction memory. The read is combinational because the
// core fetches and executes in the same cycle. Contents are normally placed
// by an external preload / hierarchical load; the write port exists so the
// array has a real driver and is tied off by the core. Contents are never
// reset.
// Ports:
//   clk      : write clock
//   i_we     : write enable
//   i_waddr  : write word address
//   i_wdata  : write data
//   i_raddr  : read word address
//   o_rdata  : read data (combinational)
// -----------------------------------------------------------------------------
module inst_mem #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [31:0]              i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [31:0]              o_rdata
);

   logic [31:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/cpu_top.sv
// -----------------------------------------------------------------------------
// cpu_top
// Single-cycle RV32I core (no data memory). Every rising clock edge retires
// the instruction addressed by pc_current_s1. LOAD, STORE, FENCE, SYSTEM and
// any undefined opcode behave as NOPs (no register write, PC+4).
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   rst_n : asynchronous reset, ACTIVE-HIGH despite the name
// Observation is hierarchical: pc_current_s1, r_regs, u_inst_mem_s1.mem.
// -----------------------------------------------------------------------------
module cpu_top
   import cpu_pkg::*;
#(
   parameter int IMEM_DEPTH = 1024
) (
   input  logic clk,
   input  logic rst_n
);

   localparam int AW = $clog2(IMEM_DEPTH);

   // Architectural state
   logic [31:0] pc_current_s1;
   logic [31:0] r_regs [0:31];

   // Decode
   logic [31:0] w_inst;
   logic [6:0]  w_opcode;
   logic [4:0]  w_rd;
   logic [4:0]  w_rs1;
   logic [4:0]  w_rs2;
   logic [2:0]  w_funct3;
   logic        w_alt;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;

   // Datapath
   logic [31:0] w_rs1_val;
   logic [31:0] w_rs2_val;
   logic        w_is_op;
   alu_op_e     w_alu_op;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_res;
   logic        w_br_taken;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_next;
   logic        w_rd_we;
   logic [31:0] w_rd_data;

   // Fetch: PC bits [1:0] are ignored and the word address wraps with the
   // memory size because only the low AW word-address bits are used.
   inst_mem #(
      .DEPTH (IMEM_DEPTH)
   ) u_inst_mem_s1 (
      .clk     (clk),
      .i_we    (1'b0),
      .i_waddr ('0),
      .i_wdata ('0),
      .i_raddr (pc_current_s1[AW+1:2]),
      .o_rdata (w_inst)
   );

   assign w_opcode = w_inst[6:0];
   assign w_rd     = w_inst[11:7];
   assign w_funct3 = w_inst[14:12];
   assign w_rs1    = w_inst[19:15];
   assign w_rs2    = w_inst[24:20];
   assign w_alt    = w_inst[30];

   assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
   assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                     w_inst[30:25], w_inst[11:8], 1'b0};
   assign w_imm_u = {w_inst[31:12], 12'b0};
   assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12],
                     w_inst[20], w_inst[30:21], 1'b0};

   // Register file read ports; x0 is hard-wired to zero on read.
   assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
   assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];

   // ALU: register form uses rs2, immediate form uses the sign-extended
   // I-immediate (which also makes SLTIU compare against a sign-extended imm).
   assign w_is_op   = (w_opcode == OPC_OP);
   assign w_alu_b   = w_is_op ? w_rs2_val : w_imm_i;
   assign w_alu_op  = alu_op_decode(w_funct3, w_alt, w_is_op);
   assign w_alu_res = alu_compute(w_alu_op, w_rs1_val, w_alu_b);

   assign w_pc_plus4 = pc_current_s1 + 32'd4;

   // Branch compare
   always_comb begin
      w_br_taken = 1'b0;
      case (w_funct3)
         F3_BEQ:  w_br_taken = (w_rs1_val == w_rs2_val);
         F3_BNE:  w_br_taken = (w_rs1_val != w_rs2_val);
         F3_BLT:  w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
         F3_BGE:  w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
         F3_BLTU: w_br_taken = (w_rs1_val <  w_rs2_val);
         F3_BGEU: w_br_taken = (w_rs1_val >= w_rs2_val);
         default: w_br_taken = 1'b0;
      endcase
   end

   // Next PC and write-back selection. Opcodes not listed fall through to
   // the defaults, which is exactly the NOP behaviour.
   always_comb begin
      w_pc_next = w_pc_plus4;
      w_rd_we   = 1'b0;
      w_rd_data = w_alu_res;
      case (w_opcode)
         OPC_LUI: begin
            w_rd_we   = 1'b1;
            w_rd_data = w_imm_u;
         end
         OPC_AUIPC: begin
            w_rd_we   = 1'b1;
            w_rd_data = pc_current_s1 + w_imm_u;
         end
         OPC_JAL: begin
            w_rd_we   = 1'b1;
            w_rd_data = w_pc_plus4;
            w_pc_next = pc_current_s1 + w_imm_j;
         end
         OPC_JALR: begin
            // rs1 is read combinationally before the edge, so rd==rs1
            // naturally uses the old value.
            w_rd_we   = 1'b1;
            w_rd_data = w_pc_plus4;
            w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
         end
         OPC_BRANCH: begin
            if (w_br_taken) begin
               w_pc_next = pc_current_s1 + w_imm_b;
            end
         end
         OPC_OP_IMM, OPC_OP: begin
            w_rd_we = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // PC and register file. Reset is asynchronous on a HIGH rst_n.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pc_current_s1 <= 32'h0;
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'h0;
         end
      end else begin
         pc_current_s1 <= w_pc_next;
         if (w_rd_we && (w_rd != 5'd0)) begin
            r_regs[w_rd] <= w_rd_data;
         end
      end
   end

endmodule

// File: tb/tb_cpu_top.sv
// -----------------------------------------------------------------------------
// tb_cpu_top
// Loads directed and random programs into the core's instruction memory,
// computes the architectural trace with an instruction-level interpreter and
// compares the core's PC and register file after every clock edge.
// -----------------------------------------------------------------------------
module tb_cpu_top;

   logic clk;
   logic rst_n;

   cpu_top #(
      .IMEM_DEPTH (1024)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef logic [31:0][31:0] regfile_t;

   logic [31:0] q_pc [$];
   regfile_t    q_regs [$];

   int n_checks = 0;
   int n_errors = 0;
   int txn      = 0;
   bit mon_en   = 1'b0;

   // Interpreter state
   logic [31:0] m_mem  [0:1023];
   logic [31:0] m_regs [0:31];
   logic [31:0] m_pc;

   // Monitor scratch
   logic [31:0] e_pc;
   regfile_t    e_regs;
   int          bad;

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] off, input logic [4:0] rd);
      return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
   endfunction

   // ---------------- memory helpers ----------------
   task automatic put(input logic [9:0] word, input logic [31:0] inst);
      m_mem[word] = inst;
      dut.u_inst_mem_s1.mem[word] = inst;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 1024; i++) put(10'(i), 32'h0);
   endtask

   // ---------------- reference interpreter ----------------
   task automatic model_step();
      logic [31:0] inst, a, b, b2, ii, ib, iu, ij, val, nxt;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        wr, taken, sub;
      inst  = m_mem[m_pc[11:2]];
      rd    = inst[11:7];
      f3    = inst[14:12];
      a     = m_regs[inst[19:15]];
      b     = m_regs[inst[24:20]];
      ii    = {{20{inst[31]}}, inst[31:20]};
      ib    = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      iu    = {inst[31:12], 12'b0};
      ij    = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      nxt   = m_pc + 32'd4;
      wr    = 1'b0;
      val   = 32'h0;
      taken = 1'b0;
      case (inst[6:0])
         7'h37: begin wr = 1'b1; val = iu; end
         7'h17: begin wr = 1'b1; val = m_pc + iu; end
         7'h6F: begin wr = 1'b1; val = m_pc + 32'd4; nxt = m_pc + ij; end
         7'h67: begin wr = 1'b1; val = m_pc + 32'd4; nxt = (a + ii) & 32'hFFFF_FFFE; end
         7'h63: begin
            case (f3)
               3'd0:    taken = (a == b);
               3'd1:    taken = (a != b);
               3'd4:    taken = ($signed(a) <  $signed(b));
               3'd5:    taken = ($signed(a) >= $signed(b));
               3'd6:    taken = (a <  b);
               3'd7:    taken = (a >= b);
               default: taken = 1'b0;
            endcase
            if (taken) nxt = m_pc + ib;
         end
         7'h13, 7'h33: begin
            b2  = (inst[6:0] == 7'h13) ? ii : b;
            sub = inst[5] && inst[30];
            wr  = 1'b1;
            case (f3)
               3'd0:    val = sub ? (a - b2) : (a + b2);
               3'd1:    val = a << b2[4:0];
               3'd2:    val = {31'b0, ($signed(a) < $signed(b2))};
               3'd3:    val = {31'b0, (a < b2)};
               3'd4:    val = a ^ b2;
               3'd5:    val = inst[30] ? 32'($signed(a) >>> b2[4:0]) : (a >> b2[4:0]);
               3'd6:    val = a | b2;
               default: val = a & b2;
            endcase
         end
         default: ;
      endcase
      if (wr && rd != 5'd0) m_regs[rd] = val;
      m_pc = nxt;
   endtask

   // ---------------- checks ----------------
   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end else begin
         $display("check %s = %08h ok", name, act);
      end
   endtask

   task automatic check_regs_zero(input string name);
      int b0;
      b0 = 0;
      for (int i = 1; i < 32; i++) if (b0 == 0 && dut.r_regs[5'(i)] !== 32'h0) b0 = i;
      n_checks++;
      if (b0 != 0) begin
         n_errors++;
         $display("FAIL %s: x%0d got %08h expected 00000000", name, b0, dut.r_regs[5'(b0)]);
      end else begin
         $display("check %s regs zero ok", name);
      end
   endtask

   // Asynchronous reset asserted mid-cycle, away from any clock edge.
   task automatic reset_check(input string name);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check32({name, "_rst_pc"}, dut.pc_current_s1, 32'h0);
      check_regs_zero({name, "_rst"});
   endtask

   // Build the expected trace while the core is held in reset, then release.
   task automatic run_program(input int ncyc, input string name);
      regfile_t snap;
      m_pc = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      for (int k = 0; k < ncyc; k++) begin
         model_step();
         for (int i = 0; i < 32; i++) snap[5'(i)] = m_regs[i];
         q_pc.push_back(m_pc);
         q_regs.push_back(snap);
      end
      $display("program %s: %0d cycles", name, ncyc);
      @(negedge clk);
      rst_n  = 1'b0;
      mon_en = 1'b1;
      for (int c = 0; c < ncyc + 10; c++) begin
         if (q_pc.size() == 0) break;
         @(negedge clk);
      end
      if (q_pc.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s timeout: got %0d pending expected 0", name, q_pc.size());
         q_pc.delete();
         q_regs.delete();
      end
      mon_en = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #1;
      if (mon_en && q_pc.size() != 0) begin
         e_pc   = q_pc.pop_front();
         e_regs = q_regs.pop_front();
         txn++;
         n_checks++;
         if (dut.pc_current_s1 !== e_pc) begin
            n_errors++;
            $display("FAIL txn %0d pc: got %08h expected %08h", txn, dut.pc_current_s1, e_pc);
         end
         bad = 0;
         for (int i = 1; i < 32; i++)
            if (bad == 0 && dut.r_regs[5'(i)] !== e_regs[5'(i)]) bad = i;
         n_checks++;
         if (bad != 0) begin
            n_errors++;
            $display("FAIL txn %0d x%0d: got %08h expected %08h", txn, bad,
                     dut.r_regs[5'(bad)], e_regs[5'(bad)]);
         end else if (dut.pc_current_s1 === e_pc) begin
            $display("txn %0d pc=%08h ok", txn, e_pc);
         end
      end
   end

   // ---------------- random program generator ----------------
   task automatic gen_random(input int len);
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      logic [6:0]  f7;
      int          kind, kmax, k, sel;
      clear_mem();
      for (int a = 0; a < len - 1; a++) begin
         rd   = 5'($urandom_range(0, 7));
         rs1  = 5'($urandom_range(0, 7));
         rs2  = 5'($urandom_range(0, 7));
         f3   = 3'($urandom_range(0, 7));
         kmax = (len - 1 - a < 4) ? (len - 1 - a) : 4;
         k    = int'($urandom_range(1, kmax));
         kind = int'($urandom_range(0, 9));
         case (kind)
            0, 1, 2, 3: begin
               imm = 12'($urandom);
               if (f3 == 3'd1) imm[11:5] = 7'h00;
               else if (f3 == 3'd5) imm[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
               put(10'(a), enc_i(imm, rs1, f3, rd, 7'h13));
            end
            4, 5: begin
               f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
               put(10'(a), enc_r(f7, rs2, rs1, f3, rd));
            end
            6: put(10'(a), enc_u(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17));
            7: begin
               sel = int'($urandom_range(0, 5));
               f3  = (sel < 2) ? 3'(sel) : 3'(sel + 2);
               put(10'(a), enc_b(13'(k * 4), rs2, rs1, f3));
            end
            8: begin
               if ($urandom_range(0, 1) == 1) put(10'(a), enc_j(21'(k * 4), rd));
               else put(10'(a), enc_i(12'((a + k) * 4 + int'($urandom_range(0, 1))),
                                      5'd0, 3'd0, rd, 7'h67));
            end
            default: begin
               sel = int'($urandom_range(0, 8));
               case (sel)
                  0:       put(10'(a), 32'h0000_2083);                  // lw x1,0(x0)
                  1:       put(10'(a), enc_s(12'($urandom), rs2, rs1, 3'd2));
                  2:       put(10'(a), 32'h0000_000F);                  // fence
                  3:       put(10'(a), 32'h0000_100F);                  // fence.i
                  4:       put(10'(a), 32'h0000_0073);                  // ecall
                  5:       put(10'(a), 32'h0010_0073);                  // ebreak
                  6:       put(10'(a), 32'h3400_92F3);                  // csrrw x5,mscratch,x1
                  7:       put(10'(a), 32'h3020_0073);                  // mret
                  default: put(10'(a), {25'($urandom), 7'h7F});         // undefined opcode
               endcase
            end
         endcase
      end
      put(10'(len - 1), enc_j(21'd0, 5'd0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      #1;
      check32("async_reset_pc", dut.pc_current_s1, 32'h0);
      check_regs_zero("async_reset");

      // NOP walk from address 0
      clear_mem();
      put(10'd0, 32'h0000_0013);
      run_program(6, "nop_walk");
      reset_check("nop_walk");

      // ALU corner cases
      clear_mem();
      put(10'd0, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13));   // addi  x1,x0,-1
      put(10'd1, enc_i(12'd1,   5'd1, 3'd3, 5'd2, 7'h13));   // sltiu x2,x1,1
      put(10'd2, enc_i(12'h404, 5'd1, 3'd5, 5'd3, 7'h13));   // srai  x3,x1,4
      put(10'd3, enc_i(12'd28,  5'd1, 3'd5, 5'd4, 7'h13));   // srli  x4,x1,28
      put(10'd4, enc_j(21'd0, 5'd0));
      run_program(8, "alu");
      check32("alu_x1", dut.r_regs[1], 32'hFFFF_FFFF);
      check32("alu_x2", dut.r_regs[2], 32'h0000_0000);
      check32("alu_x3", dut.r_regs[3], 32'hFFFF_FFFF);
      check32("alu_x4", dut.r_regs[4], 32'h0000_000F);
      reset_check("alu");

      // Branches
      clear_mem();
      put(10'd0, enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13));   // x1 = -1
      put(10'd1, enc_i(12'd1,   5'd0, 3'd0, 5'd2, 7'h13));   // x2 = 1
      put(10'd2, enc_b(13'd8, 5'd2, 5'd1, 3'd4));            // blt  -> 0x10
      put(10'd3, enc_i(12'd99,  5'd0, 3'd0, 5'd5, 7'h13));   // skipped
      put(10'd4, enc_b(13'd8, 5'd2, 5'd1, 3'd6));            // bltu not taken
      put(10'd5, enc_b(13'd8, 5'd2, 5'd1, 3'd7));            // bgeu -> 0x1C
      put(10'd6, enc_i(12'd7,   5'd0, 3'd0, 5'd6, 7'h13));   // skipped
      put(10'd7, enc_j(21'd0, 5'd0));
      run_program(8, "branch");
      check32("branch_pc", dut.pc_current_s1, 32'h0000_001C);
      check32("branch_x5", dut.r_regs[5], 32'h0);
      check32("branch_x6", dut.r_regs[6], 32'h0);
      reset_check("branch");

      // Jumps
      clear_mem();
      for (int i = 0; i < 4; i++) put(10'(i), 32'h0000_0013);
      put(10'd4, enc_j(21'd16, 5'd1));                       // jal  x1,+16 @0x10
      put(10'd5, enc_j(21'd0, 5'd0));                        // jal  x0,0   @0x14
      put(10'd8, enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'h67));     // jalr x0,x1,1 @0x20
      run_program(10, "jump");
      check32("jump_pc", dut.pc_current_s1, 32'h0000_0014);
      check32("jump_x1", dut.r_regs[1], 32'h0000_0014);
      reset_check("jump");

      // x0 and NOP-class instructions
      clear_mem();
      put(10'd0, enc_i(12'd33, 5'd0, 3'd0, 5'd5, 7'h13));    // x5 = 33
      put(10'd1, enc_i(12'd33, 5'd0, 3'd0, 5'd7, 7'h13));    // x7 = 33
      put(10'd2, enc_i(12'd5,  5'd0, 3'd0, 5'd0, 7'h13));    // addi x0,x0,5
      put(10'd3, 32'h0000_0073);                             // ecall
      put(10'd4, 32'h3400_92F3);                             // csrrw x5,mscratch,x1
      put(10'd5, enc_s(12'd0, 5'd1, 5'd0, 3'd2));            // sw x1,0(x0)
      put(10'd6, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd7));      // add x7,x0,x0
      put(10'd7, enc_j(21'd0, 5'd0));
      run_program(10, "nop_x0");
      check32("nop_x5", dut.r_regs[5], 32'd33);
      check32("nop_x7", dut.r_regs[7], 32'h0);
      check32("nop_pc", dut.pc_current_s1, 32'h0000_001C);
      reset_check("nop_x0");

      // Random programs
      for (int r = 0; r < 6; r++) begin
         gen_random(40);
         run_program(70, $sformatf("rand%0d", r));
         reset_check($sformatf("rand%0d", r));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cpu_top.md
CPU_TOP -- requirements
Module: cpu_top

Interface
REQ-001 SHALL have one parameter: IMEM_DEPTH, default 1024, instruction memory size in 32-bit words (4 KiB).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-high (rst_n=1 resets, despite the name).
REQ-004 SHALL have no other ports; program loading and results are observed hierarchically only.
REQ-005 SHALL expose internal signal pc_current_s1 (32 bit): the address of the instruction fetched and executed this cycle.
REQ-006 SHALL contain an instruction memory instance named u_inst_mem_s1 holding array mem [0:IMEM_DEPTH-1] of 32-bit words, loadable by $readmemh before/after reset.

Function
REQ-007 SHALL be a single-cycle RV32I core without data memory: one instruction completes per clock.
REQ-008 SHALL fetch combinationally: inst = mem[pc_current_s1[log2(IMEM_DEPTH)+1:2]]; PC bits [1:0] ignored; addresses wrap modulo memory size.
REQ-009 SHALL update PC each rising edge: pc+4 by default; branch target pc+B-imm if taken; pc+J-imm for JAL; (rs1+I-imm)&~1 for JALR.
REQ-010 SHALL implement LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU, ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
REQ-011 SHALL use 32-bit wrap-around arithmetic; shifts use amount [4:0]; SLT/BLT/BGE signed, SLTU/SLTIU/BLTU/BGEU unsigned; SLTIU sign-extends imm then compares unsigned.
REQ-012 SHALL write rd = pc+4 for JAL/JALR; LUI writes imm<<12; AUIPC writes pc+(imm<<12).
REQ-013 SHALL contain a 32x32 register file, 2 combinational read ports, 1 synchronous write port; x0 reads 0 and ignores writes.
REQ-014 SHALL execute LOAD, STORE, MISC-MEM (FENCE, FENCE.I), SYSTEM (ECALL, EBREAK, CSR*, MRET) and any undefined opcode as NOP: no register write, PC+4.
REQ-015 SHALL read JALR rs1 before the same cycle's write (rd==rs1 uses old value).
REQ-016 SHALL, for a taken branch whose target equals pc, keep PC constant (self-loop) indefinitely.

Reset
REQ-017 SHALL on rst_n=1 immediately set pc_current_s1=32'h0 and all registers x1..x31=0, independent of clk.
REQ-018 SHALL resume fetching at address 0 on the first rising edge after rst_n returns to 0; a reset mid-program restarts from 0.
REQ-019 SHALL NOT clear instruction memory contents on reset.

Structure
REQ-020 SHALL place opcode constants (7-bit), funct3 codes and an ALU-operation enum in package cpu_pkg.
REQ-021 SHALL use sub-module inst_mem (instance u_inst_mem_s1); decode, ALU, branch compare and register file may live inside cpu_top.

Verification
REQ-022 Reset: rst_n pulse, mem[0]=00000013 -> pc_current_s1=0 during reset, 4 after first edge, 8 after second.
REQ-023 ALU: ADDI x1,x0,-1; SLTIU x2,x1,1; SRAI x3,x1,4; SRLI x4,x1,28 -> x1=FFFFFFFF, x2=0, x3=FFFFFFFF, x4=0000000F.
REQ-024 Branches: x1=-1, x2=1; BLT x1,x2,+8 taken (pc+8); BLTU x1,x2,+8 not taken (pc+4); BGEU x1,x2 taken.
REQ-025 Jumps: JAL x1,+16 at 0x10 -> pc=0x20, x1=0x14; JALR x0,x1,1 -> pc=0x14; JAL x0,0 -> pc stays constant.
REQ-026 x0/NOP: ADDI x0,x0,5 then ECALL, CSRRW x5, SW -> x0=0, x5 unchanged, pc advances by 4 each.
REQ-027 Compliance: rv32ui-p no-load/store images (add..xori, incl. fence_i) -> within 2000 cycles pc_current_s1 moves from the test's final branch address to its pass address (e.g. bgeu 0x4EC->0x504, add 0x678->0x690).
